// File: rtl/byte_serial_adder.sv
// byte_serial_adder: bit-serial ripple adder, LSB first, one bit per clock.
// Operands and carry-in are latched on an accepted start. The sum and
// carry-out registers update only on the edge that raises done, and hold
// their values until the next done pulse.
module byte_serial_adder #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] byte_a,
    input  logic [DATA_WIDTH-1:0] byte_b,
    input  logic                  byte_carry_in,
    output logic [DATA_WIDTH-1:0] byte_sum,
    output logic                  byte_carry_out,
    output logic                  busy,
    output logic                  done
);
    localparam int            CW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_a_sh, r_b_sh, r_s_sh;
    logic                  r_c;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_sum;
    logic                  r_cout;

    logic                  w_bit_s;
    logic                  w_c_nxt;
    logic [DATA_WIDTH-1:0] w_s_sh_nxt;
    logic                  w_load;
    logic                  w_last;

    // Full-adder slice on the current LSBs; new sum bit enters at the MSB.
    assign w_bit_s    = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
    assign w_c_nxt    = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_c) | (r_b_sh[0] & r_c);
    assign w_s_sh_nxt = {w_bit_s, r_s_sh[DATA_WIDTH-1:1]};
    // start only counts when no add is in flight
    assign w_load     = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last     = (r_state == S_RUN) && (r_cnt == LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; DONE re-enters RUN directly on start for back-to-back adds
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state: done is exactly the single DONE cycle
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: load on accepted start, shift one bit per RUN cycle, commit on last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_s_sh <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_load) begin
            r_a_sh <= byte_a;
            r_b_sh <= byte_b;
            r_s_sh <= '0;
            r_c    <= byte_carry_in;
            r_cnt  <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh <= {1'b0, r_a_sh[DATA_WIDTH-1:1]};
            r_b_sh <= {1'b0, r_b_sh[DATA_WIDTH-1:1]};
            r_s_sh <= w_s_sh_nxt;
            r_c    <= w_c_nxt;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
                r_sum  <= w_s_sh_nxt;
                r_cout <= w_c_nxt;
            end
        end
    end

    assign byte_sum       = r_sum;
    assign byte_carry_out = r_cout;

endmodule

// File: doc/byte_serial_adder.md
# byte_serial_adder

Bit-serial ripple adder: the addition counterpart to the team's byte-wide subtractor, using the same operand/carry/start/done conventions. It latches two DATA_WIDTH-bit operands and a carry-in on a start request, then adds one bit per clock, LSB first, through a single carry flip-flop. It presents the sum and carry-out with a one-cycle done pulse. It serves as the area-minimal adder in the arithmetic lab datapath, alongside the subtractor.

## Interface
- DATA_WIDTH, 8, operand/sum width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on rising clk, accepted only in IDLE or DONE
- byte_a  input  DATA_WIDTH  operand A, sampled with accepted start
- byte_b  input  DATA_WIDTH  operand B, sampled with accepted start
- byte_carry_in  input  1  carry into bit 0, sampled with accepted start
- byte_sum  output  DATA_WIDTH  result of last completed add
- byte_carry_out  output  1  carry out of bit DATA_WIDTH-1 of last completed add
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse: byte_sum/byte_carry_out just updated

## Operation
- Internal state:
  - shift registers a_sh, b_sh, s_sh (DATA_WIDTH each)
  - carry flop c
  - bit counter cnt, width clog2(DATA_WIDTH)
  - FSM state
- IDLE:
  - start=1 → load a_sh=byte_a, b_sh=byte_b, c=byte_carry_in, cnt=0; go RUN.
  - start=0 → stay.
- RUN, each edge:
  - s = a_sh[0]^b_sh[0]^c
  - c ← majority(a_sh[0], b_sh[0], c)
  - s_sh ← {s, s_sh[DATA_WIDTH-1:1]}
  - a_sh, b_sh shift right by 1
  - cnt ← cnt+1
  - When cnt==DATA_WIDTH-1 on this edge:
    - byte_sum ← final s_sh value, including this bit
    - byte_carry_out ← new c
    - done ← 1
    - go DONE
- DONE, lasts one cycle:
  - start=1 → reload as in IDLE and go RUN (back-to-back).
  - Otherwise go IDLE.
  - done deasserts on the next edge either way.
- start in RUN is ignored; operand inputs in RUN are don't-care.
- byte_sum and byte_carry_out hold between done pulses and change only on the edge that raises done.
- Arithmetic is modulo 2^DATA_WIDTH with carry-out: {byte_carry_out, byte_sum} = byte_a + byte_b + byte_carry_in.
- No overflow flag; unsigned semantics only.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, cnt=0, c=0, all shift registers 0
  - byte_sum=0, byte_carry_out=0, busy=0, done=0
  - Takes effect immediately, without a clock.
- Reset deassertion is synchronized externally; the first start is accepted on the first rising edge with rst_n=1.
- Latency:
  - start is accepted at edge E0.
  - Bits are processed at edges E1..E_DATA_WIDTH.
  - done and the results are valid after edge E_DATA_WIDTH, i.e. DATA_WIDTH cycles after acceptance.
- busy: 1 from E0 until E_DATA_WIDTH, then 0 in DONE.
- Throughput:
  - back-to-back, one result per DATA_WIDTH+1 cycles
  - start held high continuously → a new add is accepted every DATA_WIDTH+1 cycles
- Reset mid-RUN aborts the add. No done pulse; outputs go to 0.
- The operation is pure add; there is no borrow/invert mode.

## Test plan
- byte_a=8'h3C, byte_b=8'h05, carry_in=0, start pulse → done exactly 8 edges after acceptance; byte_sum=8'h41, carry_out=0; busy high 8 cycles.
- 8'hFF + 8'h01, carry_in=0 → byte_sum=8'h00, carry_out=1. Then 8'hFF + 8'hFF, carry_in=1 → byte_sum=8'hFF, carry_out=1.
- start held 1 with inputs changing every cycle during RUN → only operands at acceptance used (8'h10+8'h20 → 8'h30); next add accepted in DONE cycle; done pulses spaced 9 cycles.
- rst_n low 3 cycles after acceptance of 8'hAA+8'h55 → outputs 0 immediately; no done; after release, a new add of 8'h01+8'h01 gives 8'h02 normally.
- Random sweep of 10k vectors, DATA_WIDTH=8 and DATA_WIDTH=4 → {carry_out,sum} matches the reference model a+b+cin; done is never wider than 1 cycle; outputs stable between pulses.
